sprite_anim_layer: RTL and testbench

Parametrised sprite layer that places one multi-frame sprite sheet at a runtime (x,y) position on the 640x480 raster, with optional horizontal mirroring and a frame-counted animation sequencer (loop or one-shot). It generates the sprite-sheet ROM address from DrawX/DrawY and pipelines the hit/blank qualifiers to match ROM latency. It emits a palette index plus an opaque flag for the downstream layer compositor. The palette lookup and colour mux live outside this block.

---
 rtl/sprite_anim_layer.sv | 138 +++++++++++++
 tb/tb_sprite_anim_layer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_layer.sv
// Sprite layer: hit test, mirrored ROM addressing and a frame-counted loop/one-shot animation sequencer.
// Latency 2 cycles from DrawX/DrawY to pix_idx/pix_opaque; no backpressure, one pixel per clock.
module sprite_anim_layer #(
  parameter int SPR_W      = 50,
  parameter int SPR_H      = 64,
  parameter int FRAMES     = 4,
  parameter int ADDR_W     = 14,
  parameter int IDX_W      = 3,
  parameter int TRANSP_IDX = 0,
  parameter int FRAME_DIV  = 6
) (
  input  logic                                       vga_clk,
  input  logic                                       reset_n,
  input  logic [9:0]                                 DrawX,
  input  logic [9:0]                                 DrawY,
  input  logic                                       blank,
  input  logic                                       frame_tick,
  input  logic [9:0]                                 sprite_x,
  input  logic [9:0]                                 sprite_y,
  input  logic                                       flip_h,
  input  logic                                       start,
  input  logic                                       loop_mode,
  output logic [ADDR_W-1:0]                          rom_address,
  input  logic [IDX_W-1:0]                           rom_q,
  output logic [IDX_W-1:0]                           pix_idx,
  output logic                                       pix_opaque,
  output logic [((FRAMES > 1) ? $clog2(FRAMES) : 1)-1:0] frame_idx,
  output logic                                       busy,
  output logic                                       anim_done
);

  localparam int FI_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [10:0]       SPR_W11    = 11'(SPR_W);
  localparam logic [10:0]       SPR_H11    = 11'(SPR_H);
  localparam logic [31:0]       SPR_W32    = 32'(SPR_W);
  localparam logic [31:0]       FRAME_SZ   = 32'(SPR_W * SPR_H);
  localparam logic [31:0]       LAST_FR32  = 32'(FRAMES - 1);
  localparam logic [FI_W-1:0]   LAST_FRAME = FI_W'(FRAMES - 1);
  localparam logic [DIV_W-1:0]  LAST_DIV   = DIV_W'(FRAME_DIV - 1);
  localparam logic [IDX_W-1:0]  TRANSP     = IDX_W'(TRANSP_IDX);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t            state_q, state_d;
  logic [FI_W-1:0]   frame_idx_q, frame_idx_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              loop_q, loop_d;
  logic              anim_done_q, anim_done_d;
  logic              hit_vld_q, hit_vld_d;
  logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;
  logic              pix_opaque_q, pix_opaque_d;

  logic [10:0] dx, dy, col;
  logic        hit;
  logic        one_shot_end;

  // 11-bit compare keeps sprites near the right/bottom edge from wrapping to column/row 0.
  always_comb begin
    dx  = {1'b0, DrawX} - {1'b0, sprite_x};
    dy  = {1'b0, DrawY} - {1'b0, sprite_y};
    hit = (DrawX >= sprite_x) && ({1'b0, DrawX} < ({1'b0, sprite_x} + SPR_W11)) &&
          (DrawY >= sprite_y) && ({1'b0, DrawY} < ({1'b0, sprite_y} + SPR_H11));
    col = flip_h ? (SPR_W11 - 11'd1 - dx) : dx;
    rom_address = '0;
    if (hit) begin
      rom_address = ADDR_W'(32'(frame_idx_q) * FRAME_SZ + 32'(dy) * SPR_W32 + 32'(col));
    end
  end

  always_comb begin
    hit_vld_d    = hit & blank;
    pix_idx_d    = hit_vld_q ? rom_q : '0;
    pix_opaque_d = hit_vld_q && (rom_q != TRANSP);
  end

  // One-shot finishes on the step that lands on the last frame.
  assign one_shot_end = (32'(frame_idx_q) + 32'd1) >= LAST_FR32;

  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    div_cnt_d   = div_cnt_q;
    loop_d      = loop_q;
    anim_done_d = 1'b0;
    if (start) begin
      state_d     = PLAY;
      frame_idx_d = '0;
      div_cnt_d   = '0;
      loop_d      = loop_mode;
    end else if (state_q == PLAY && frame_tick) begin
      if (div_cnt_q == LAST_DIV) begin
        div_cnt_d = '0;
        if (loop_q) begin
          frame_idx_d = (frame_idx_q == LAST_FRAME) ? '0 : frame_idx_q + FI_W'(1);
        end else if (one_shot_end) begin
          frame_idx_d = LAST_FRAME;
          state_d     = DONE;
          anim_done_d = 1'b1;
        end else begin
          frame_idx_d = frame_idx_q + FI_W'(1);
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      frame_idx_q  <= '0;
      div_cnt_q    <= '0;
      loop_q       <= 1'b0;
      anim_done_q  <= 1'b0;
      hit_vld_q    <= 1'b0;
      pix_idx_q    <= '0;
      pix_opaque_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_idx_q  <= frame_idx_d;
      div_cnt_q    <= div_cnt_d;
      loop_q       <= loop_d;
      anim_done_q  <= anim_done_d;
      hit_vld_q    <= hit_vld_d;
      pix_idx_q    <= pix_idx_d;
      pix_opaque_q <= pix_opaque_d;
    end
  end

  assign pix_idx    = pix_idx_q;
  assign pix_opaque = pix_opaque_q;
  assign frame_idx  = frame_idx_q;
  assign busy       = (state_q == PLAY);
  assign anim_done  = anim_done_q;

endmodule

// File: tb/tb_sprite_anim_layer.sv
// Randomized bench for sprite_anim_layer against a tick-counting animation model and a pixel scoreboard.
module tb_sprite_anim_layer;

  localparam int SPR_W      = 50;
  localparam int SPR_H      = 64;
  localparam int FRAMES     = 4;
  localparam int ADDR_W     = 14;
  localparam int IDX_W      = 3;
  localparam int TRANSP_IDX = 0;
  localparam int FRAME_DIV  = 6;
  localparam int FI_W       = 2;
  localparam int DONE_STEP  = (FRAMES > 1) ? FRAMES - 1 : 1;

  logic              vga_clk = 1'b0;
  logic              reset_n;
  logic [9:0]        DrawX, DrawY, sprite_x, sprite_y;
  logic              blank, frame_tick, flip_h, start, loop_mode;
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pix_idx;
  logic              pix_opaque;
  logic [FI_W-1:0]   frame_idx;
  logic              busy, anim_done;

  logic [IDX_W-1:0] mem [0:(1<<ADDR_W)-1];

  int errors = 0;
  int checks = 0;

  // Animation model: ticks counted since start; frame derived arithmetically.
  int m_ticks = 0;
  bit m_busy = 0, m_loop = 0, m_pulse = 0;
  logic [IDX_W-1:0] cur_idx, prev_idx;
  logic             cur_op, prev_op;
  int lit_addr = -1;

  sprite_anim_layer #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .ADDR_W(ADDR_W),
    .IDX_W(IDX_W), .TRANSP_IDX(TRANSP_IDX), .FRAME_DIV(FRAME_DIV)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .frame_tick(frame_tick), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .flip_h(flip_h), .start(start), .loop_mode(loop_mode), .rom_address(rom_address),
    .rom_q(rom_q), .pix_idx(pix_idx), .pix_opaque(pix_opaque), .frame_idx(frame_idx),
    .busy(busy), .anim_done(anim_done)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) rom_q <= mem[rom_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_frame();
    int steps;
    steps = m_ticks / FRAME_DIV;
    if (m_loop) return steps % FRAMES;
    return (steps > FRAMES - 1) ? FRAMES - 1 : steps;
  endfunction

  task automatic model_reset();
    m_ticks = 0; m_busy = 0; m_loop = 0; m_pulse = 0;
    prev_idx = '0; prev_op = 1'b0;
  endtask

  task automatic step();
    bit hit;
    int dx, dy, col, addr;
    @(negedge vga_clk);
    #1;
    if (!reset_n) model_reset();
    hit = (int'(DrawX) >= int'(sprite_x)) && (int'(DrawX) < int'(sprite_x) + SPR_W) &&
          (int'(DrawY) >= int'(sprite_y)) && (int'(DrawY) < int'(sprite_y) + SPR_H);
    dx = int'(DrawX) - int'(sprite_x);
    dy = int'(DrawY) - int'(sprite_y);
    col = flip_h ? SPR_W - 1 - dx : dx;
    addr = (m_frame() * SPR_W * SPR_H + dy * SPR_W + col) % (1 << ADDR_W);
    if (lit_addr >= 0) chk("addr_literal", 32'(rom_address), 32'(lit_addr));
    if (hit) chk("rom_address", 32'(rom_address), 32'(addr));
    cur_idx = '0;
    cur_op  = 1'b0;
    if (reset_n && hit && blank) begin
      cur_idx = mem[addr];
      cur_op  = (int'(mem[addr]) != TRANSP_IDX);
    end
    @(posedge vga_clk);
    #1;
    if (!reset_n) model_reset();
    chk("pix_idx", 32'(pix_idx), 32'(prev_idx));
    chk("pix_opaque", 32'(pix_opaque), 32'(prev_op));
    prev_idx = cur_idx;
    prev_op  = cur_op;
    if (reset_n) begin
      m_pulse = 0;
      if (start) begin
        m_busy = 1; m_ticks = 0; m_loop = loop_mode;
      end else if (m_busy && frame_tick) begin
        m_ticks++;
        if (!m_loop && m_ticks == DONE_STEP * FRAME_DIV) begin
          m_busy = 0; m_pulse = 1;
        end
      end
    end
    chk("frame_idx", 32'(frame_idx), 32'(m_frame()));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("anim_done", 32'(anim_done), 32'(m_pulse));
  endtask

  task automatic rand_pix();
    int x, y;
    sprite_x = 10'($urandom_range(0, 639));
    sprite_y = 10'($urandom_range(0, 479));
    x = int'(sprite_x) + int'($urandom_range(0, 60)) - 5;
    y = int'(sprite_y) + int'($urandom_range(0, 74)) - 5;
    DrawX = 10'((x < 0) ? 0 : (x > 639) ? 639 : x);
    DrawY = 10'((y < 0) ? 0 : (y > 479) ? 479 : y);
    blank  = ($urandom_range(0, 7) != 0);
    flip_h = $urandom_range(0, 1) == 1;
  endtask

  task automatic set_pos(input int sx, input int sy, input int x, input int y, input bit f, input bit b);
    sprite_x = 10'(sx); sprite_y = 10'(sy); DrawX = 10'(x); DrawY = 10'(y);
    flip_h = f; blank = b;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = IDX_W'($urandom);
    model_reset();
    reset_n = 1'b0; start = 1'b0; frame_tick = 1'b0; loop_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_pix();
      start = $urandom_range(0, 1) == 1;
      frame_tick = $urandom_range(0, 1) == 1;
      step();
    end
    start = 1'b0; frame_tick = 1'b0;
    reset_n = 1'b1;
    step();

    // Directed addressing, flip, clip and blank points.
    set_pos(100, 50, 103, 52, 0, 1); lit_addr = 103; step();
    set_pos(100, 50, 103, 52, 1, 1); lit_addr = 146; step();
    set_pos(620, 50, 639, 52, 0, 1); lit_addr = 119; step();
    lit_addr = -1;
    set_pos(620, 50, 0, 52, 0, 1); step();
    set_pos(100, 50, 103, 52, 0, 0); step();
    mem[103] = '0;
    set_pos(100, 50, 103, 52, 0, 1); step();
    step();

    // Loop playback.
    loop_mode = 1'b1; start = 1'b1; step(); start = 1'b0; loop_mode = 1'b0;
    for (int t = 0; t < 30; t++) begin
      rand_pix(); frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end

    // One-shot to completion, then start colliding with a tick.
    loop_mode = 1'b0; start = 1'b1; step(); start = 1'b0;
    for (int t = 0; t < 22; t++) begin
      rand_pix(); frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
    for (int t = 0; t < 8; t++) begin frame_tick = 1'b1; step(); end
    start = 1'b1; step(); start = 1'b0;
    for (int t = 0; t < 9; t++) step();
    frame_tick = 1'b0;

    // Reset in the middle of playback.
    reset_n = 1'b0; step(); reset_n = 1'b1; step();

    for (int i = 0; i < 3000; i++) begin
      rand_pix();
      frame_tick = $urandom_range(0, 2) == 0;
      start      = $urandom_range(0, 149) == 0;
      loop_mode  = $urandom_range(0, 1) == 1;
      reset_n    = $urandom_range(0, 999) != 0;
      step();
    end
    reset_n = 1'b1; start = 1'b0; frame_tick = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
